// File: rtl/phys_mem_responder.sv
// -----------------------------------------------------------------------------
// phys_mem_responder
//
// Word-addressed physical memory that answers one request at a time after a
// fixed access latency. It serves translated loads/stores from virtual_mem and
// also backs page-table walks.
//
// Handshake:
//   A request is accepted on an edge where the block is idle and req_valid = 1.
//   The request, the word index and the fault decision are latched at that
//   edge, and busy rises. The response cycle (ready = 1) is the cycle that ends
//   at edge N + LATENCY, where N is the acceptance edge. The block then returns
//   to idle, so the next request can be accepted at edge N + LATENCY + 1. That
//   gives one transaction per LATENCY + 1 cycles. Requests that arrive while
//   busy are dropped without any side effect.
//
// Parameters:
//   DATA_W   data word width in bits
//   DEPTH    number of words; a power of two, >= 2
//   LATENCY  cycles from acceptance to the ready sample; 1..15
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset
//   req_valid    request strobe, sampled only while idle
//   req_write    1 = write, 0 = read
//   req_address  byte address; word index = req_address[2 +: log2(DEPTH)]
//   req_wdata    write data
//   rdata        response data (read data, write echo, or 0 on fault);
//                held until the next response
//   ready        one-cycle response pulse
//   busy         high from acceptance through the response cycle
//   addr_fault   qualified by ready; out-of-range or misaligned address
// -----------------------------------------------------------------------------
module phys_mem_responder #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_address,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              addr_fault
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  // Byte-address limit. It is held in 33 bits so that DEPTH * 4 = 2^32 still
  // compares correctly.
  localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                write_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                fault_q;

  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                busy_q;
  logic                addr_fault_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                req_fault;
  logic [IDX_W-1:0]    req_idx;

  // The full 32-bit address is compared, so addresses above the array fault.
  // They are not wrapped onto a lower index.
  assign req_fault = ({1'b0, req_address} >= LIMIT) || (req_address[1:0] != 2'b00);
  assign req_idx   = req_address[2 +: IDX_W];

  // ---------------------------------------------------------------------------
  // Access performed on the edge that enters RESP.
  // When LATENCY = 1 that edge is also the acceptance edge. In that case the
  // live request is used directly. Otherwise the latched copy is used.
  // ---------------------------------------------------------------------------
  logic                eff_write;
  logic [IDX_W-1:0]    eff_idx;
  logic [DATA_W-1:0]   eff_wdata;
  logic                eff_fault;
  logic                enter_resp;
  logic [DATA_W-1:0]   rdata_d;
  logic                fault_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // otherwise a latch would be inferred.
    eff_write  = write_q;
    eff_idx    = idx_q;
    eff_wdata  = wdata_q;
    eff_fault  = fault_q;
    enter_resp = 1'b0;
    rdata_d    = '0;

    if (state_q == ST_IDLE) begin
      eff_write = req_write;
      eff_idx   = req_idx;
      eff_wdata = req_wdata;
      eff_fault = req_fault;
    end

    if ((state_q == ST_IDLE) && req_valid && (LATENCY == 1)) begin
      enter_resp = 1'b1;
    end
    if ((state_q == ST_WAIT) && (cnt_q == 4'd1)) begin
      enter_resp = 1'b1;
    end

    // A faulting request returns zero. A write echoes its data. A read returns
    // the stored word.
    if (!eff_fault) begin
      rdata_d = eff_write ? eff_wdata : mem_q[eff_idx];
    end
    fault_d = eff_fault;
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from values taken before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            fault_q <= req_fault;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end

        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
          end
        end

        ST_RESP: begin
          // Any request seen in this cycle is ignored. Acceptance resumes
          // from idle on the following edge.
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      // rdata and addr_fault change only when a response is produced.
      // Between responses they hold their last value.
      if (enter_resp) begin
        ready_q      <= 1'b1;
        rdata_q      <= rdata_d;
        addr_fault_q <= fault_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset. Its contents survive reset, and leaving the
  // reset out lets it map onto RAM macros. The write is still gated by reset,
  // so a transaction aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && eff_write && !eff_fault) begin
      mem_q[eff_idx] <= eff_wdata;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign addr_fault = addr_fault_q;

endmodule

// File: tb/tb_phys_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for phys_mem_responder.
// Two instances share one request bus:
//   u_a : DEPTH = 1024, LATENCY = 4 (main target)
//   u_b : DEPTH = 16,   LATENCY = 1 (minimum-latency corner)
// Outputs are sampled on the falling edge. Inputs are driven on the falling
// edge. A request accepted at rising edge N is expected to show ready in the
// cycle that ends at edge N + LATENCY.
// -----------------------------------------------------------------------------
module tb_phys_mem_responder;

  localparam int LAT_A   = 4;
  localparam int LAT_B   = 1;
  localparam int DEPTH_A = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_wdata = '0;

  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, busy_a, busy_b, fault_a, fault_b;

  always #5 clk = ~clk;

  phys_mem_responder #(.DATA_W(32), .DEPTH(DEPTH_A), .LATENCY(LAT_A)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .addr_fault(fault_a)
  );

  phys_mem_responder #(.DATA_W(32), .DEPTH(16), .LATENCY(LAT_B)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .addr_fault(fault_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model of u_a: a word array plus a flag per word that records
  // whether the word holds a known value.
  logic [31:0] model_mem [DEPTH_A];
  bit          model_known [DEPTH_A];

  function automatic bit model_fault(input logic [31:0] addr, input int depth);
    return (64'(addr) >= 64'(depth) * 64'd4) || ((addr % 4) != 0);
  endfunction

  // Applies one transaction to the model. It returns the expected rdata and
  // fault, and whether the expected rdata is known.
  task automatic model_apply(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] exp_rd, output logic exp_flt, output bit rd_known);
    int idx;
    idx      = int'(addr / 4) % DEPTH_A;
    exp_flt  = model_fault(addr, DEPTH_A);
    exp_rd   = '0;
    rd_known = 1'b1;
    if (!exp_flt) begin
      if (wr) begin
        model_mem[idx]   = wd;
        model_known[idx] = 1'b1;
        exp_rd           = wd;
      end else begin
        exp_rd   = model_mem[idx];
        rd_known = model_known[idx];
      end
    end
  endtask

  // Waits, with a bound, until both instances are idle.
  task automatic wait_idle();
    for (int k = 0; k < 40 && (busy_a || busy_b); k++) @(negedge clk);
  endtask

  // One transaction. rvec[j] and bvec[j] record ready and busy at the falling
  // edge after rising edge N + j. When junk = 1, random requests are driven
  // while the target is busy.
  task automatic do_txn(input bit sel_b, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit junk,
                        output logic [31:0] rd, output logic flt,
                        output logic [15:0] rvec, output logic [15:0] bvec);
    int lat;
    lat  = sel_b ? LAT_B : LAT_A;
    rd   = '0;
    flt  = 1'b0;
    rvec = '0;
    bvec = '0;
    @(negedge clk);
    wait_idle();
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_wdata   = wd;
    @(posedge clk);
    for (int j = 0; j <= lat; j++) begin
      @(negedge clk);
      rvec[j] = sel_b ? ready_b : ready_a;
      bvec[j] = sel_b ? busy_b : busy_a;
      if (j == lat - 1) begin
        rd  = sel_b ? rdata_b : rdata_a;
        flt = sel_b ? fault_b : fault_a;
      end
      if (j < lat && junk) begin
        req_valid   = 1'($urandom_range(0, 1));
        req_write   = 1'($urandom_range(0, 1));
        req_address = $urandom;
        req_wdata   = $urandom;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd;
    logic        flt, eflt;
    logic [15:0] rvec, bvec;
    logic [15:0] exp_rvec_a, exp_bvec_a;
    bit          known;
    int          pulses;
    logic [31:0] cap;

    exp_rvec_a = 16'(1) << (LAT_A - 1);
    exp_bvec_a = (16'(1) << LAT_A) - 16'd1;

    // ---------------- reset ----------------
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_ready_a", 32'(ready_a), 32'd0);
    check("reset_busy_a",  32'(busy_a),  32'd0);
    check("reset_rdata_a", rdata_a,      32'd0);
    check("reset_fault_a", 32'(fault_a), 32'd0);
    check("reset_ready_b", 32'(ready_b), 32'd0);
    check("reset_busy_b",  32'(busy_b),  32'd0);

    // ---------------- table-driven vectors on u_a ----------------
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
    tbl[3]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0020, 32'h0000_1111, 32'h0000_1111, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0030, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0};
    tbl[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_A5A5, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_1010, 32'h1234_5678, 32'h0,         1'b1};
    tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[11] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0BAD, 32'h0,         1'b1};
    tbl[12] = '{1'b1, 32'h0000_0022, 32'h0000_0099, 32'h0,         1'b1};
    tbl[13] = '{1'b0, 32'h0000_0020, 32'h0,         32'h0000_1111, 1'b0};

    for (int i = 0; i < 14; i++) begin
      do_txn(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wd, 1'b0, rd, flt, rvec, bvec);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_fault", i), 32'(flt), 32'(tbl[i].exp_flt));
      check($sformatf("tbl%0d_ready_timing", i), 32'(rvec), 32'(exp_rvec_a));
      check($sformatf("tbl%0d_busy_timing", i), 32'(bvec), 32'(exp_bvec_a));
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wd, erd, eflt, known);
    end

    // ---------------- request during WAIT is dropped ----------------
    @(negedge clk);
    wait_idle();
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h10; req_wdata = '0;
    @(posedge clk);
    pulses = 0;
    cap    = '0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (ready_a) begin
        pulses++;
        cap = rdata_a;
      end
      if (j == 0) begin
        req_valid = 1'b1; req_write = 1'b1; req_address = 32'h20; req_wdata = 32'd5;
      end else begin
        req_valid = 1'b0;
      end
    end
    check("drop_pulse_count", 32'(pulses), 32'd1);
    check("drop_first_rdata", cap, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, rd, flt, rvec, bvec);
    check("drop_readback_0x20", rd, 32'h0000_1111);

    // ---------------- reset during WAIT aborts the write ----------------
    @(negedge clk);
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h30; req_wdata = 32'd7;
    @(posedge clk);
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (ready_a) pulses++;
      req_valid = 1'b0;
      if (j == 1 || j == 2) reset = 1'b0;
      else                  reset = 1'b1;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    check("abort_busy_low", 32'(busy_a), 32'd0);
    check("abort_rdata_cleared", rdata_a, 32'd0);
    do_txn(1'b0, 1'b0, 32'h30, 32'h0, 1'b0, rd, flt, rvec, bvec);
    check("abort_readback_0x30", rd, 32'h0000_0001);
    check("abort_readback_timing", 32'(rvec), 32'(exp_rvec_a));

    // ---------------- randomized traffic against the model ----------------
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic [31:0] addr, wd;
      int          kind, idx;
      kind = int'($urandom_range(0, 9));
      idx  = ($urandom_range(0, 7) == 0) ? DEPTH_A - 1 : int'($urandom_range(0, 31));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (kind == 0)      addr = $urandom | 32'h0000_1000;
      else if (kind == 1) addr = 32'(idx * 4) + 32'($urandom_range(1, 3));
      else                addr = 32'(idx * 4);
      do_txn(1'b0, wr, addr, wd, 1'b1, rd, flt, rvec, bvec);
      model_apply(wr, addr, wd, erd, eflt, known);
      if (known) check($sformatf("rnd%0d_rdata@%08h", n, addr), rd, erd);
      check($sformatf("rnd%0d_fault@%08h", n, addr), 32'(flt), 32'(eflt));
      check($sformatf("rnd%0d_timing", n), 32'({bvec[7:0], rvec[7:0]}),
            32'({exp_bvec_a[7:0], exp_rvec_a[7:0]}));
    end

    // ---------------- LATENCY = 1 instance ----------------
    do_txn(1'b1, 1'b1, 32'h0, 32'hA0A0_0000, 1'b0, rd, flt, rvec, bvec);
    check("lat1_write0_echo", rd, 32'hA0A0_0000);
    check("lat1_write0_timing", 32'({bvec[1:0], rvec[1:0]}), 32'b0101);
    do_txn(1'b1, 1'b1, 32'h4, 32'hB4B4_0004, 1'b0, rd, flt, rvec, bvec);
    check("lat1_write4_echo", rd, 32'hB4B4_0004);
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rd, flt, rvec, bvec);
    check("lat1_oob_fault", 32'(flt), 32'd1);
    check("lat1_oob_rdata", rd, 32'd0);

    // Back-to-back reads with req_valid held high.
    @(negedge clk);
    wait_idle();
    req_valid = 1'b1; req_write = 1'b0; req_address = 32'h0;
    @(posedge clk);
    rvec = '0;
    bvec = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rvec[j] = ready_b;
      bvec[j] = busy_b;
      if (j == 0) begin
        check("lat1_b2b_rdata0", rdata_b, 32'hA0A0_0000);
        req_address = 32'h4;
      end
      if (j == 2) begin
        check("lat1_b2b_rdata4", rdata_b, 32'hB4B4_0004);
        req_valid = 1'b0;
      end
    end
    check("lat1_b2b_ready_pattern", 32'(rvec[3:0]), 32'b0101);
    check("lat1_b2b_busy_pattern",  32'(bvec[3:0]), 32'b0101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
